// File: rtl/m68k_bus_ctrl_pkg.sv
// Shared types and constants for the 68000 bus-cycle controller.
// Holds the FSM state encoding and the select-class decode used by the top level.
package m68k_bus_pkg;

  typedef enum logic [2:0] {IDLE, ROM, WAIT, ACK, IACK} state_t;

  typedef enum logic [2:0] {
    SEL_RAM, SEL_SHARED, SEL_PAL, SEL_VBLANK, SEL_INT_EN, SEL_REG, SEL_OPEN
  } sel_t;

  localparam logic [2:0]  FC_IACK  = 3'b111;
  localparam logic [2:0]  IPL_LVL4 = 3'b011;
  localparam logic [2:0]  IPL_NONE = 3'b111;
  localparam logic [15:0] OPEN_BUS = 16'hFFFF;
  localparam int          CNT_W    = 4;

  // Memory selects outrank register selects; nothing selected is unmapped.
  function automatic sel_t decode_sel(input logic ram, input logic shared,
                                      input logic pal, input logic vbl,
                                      input logic int_en, input logic reg_sel);
    if (ram)          return SEL_RAM;
    else if (shared)  return SEL_SHARED;
    else if (pal)     return SEL_PAL;
    else if (vbl)     return SEL_VBLANK;
    else if (int_en)  return SEL_INT_EN;
    else if (reg_sel) return SEL_REG;
    else              return SEL_OPEN;
  endfunction

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// 68000 CPU-side bus bundle: strobes, address/data and the acknowledge/interrupt lines.
// master = CPU core, slave = bus controller.
interface m68k_bus_if;
  logic        cpu_as_n;
  logic        cpu_rw;
  logic [2:0]  cpu_fc;
  logic [23:0] cpu_a;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        cpu_dtack_n;
  logic        cpu_vpa_n;
  logic [2:0]  cpu_ipl_n;

  modport master (
    output cpu_as_n, cpu_rw, cpu_fc, cpu_a, cpu_dout,
    input  cpu_din, cpu_dtack_n, cpu_vpa_n, cpu_ipl_n
  );

  modport slave (
    input  cpu_as_n, cpu_rw, cpu_fc, cpu_a, cpu_dout,
    output cpu_din, cpu_dtack_n, cpu_vpa_n, cpu_ipl_n
  );
endinterface

// File: rtl/m68k_bus_ctrl_irq_ctrl.sv
// VBLANK level-4 interrupt: edge detect, enable register and pending flag.
// The pending flag is cleared by IACK entry or by writing int_en=0; a new edge wins.
module irq_ctrl
  import m68k_bus_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       vblank,
  input  logic       iack_clr,
  input  logic       int_en_wr,
  input  logic       int_en_val,
  output logic [2:0] ipl_n
);

  logic vblank_q;
  logic int_en;
  logic irq_pend;
  logic vblank_rise;

  assign vblank_rise = vblank & ~vblank_q;

  // NOTE: state registers use non-blocking assignments so every read in this block sees the pre-edge value.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_q <= 1'b0;
      int_en   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (int_en_wr) int_en <= int_en_val;
      // The set uses the old int_en, so an enabling write cannot catch a same-cycle edge.
      if (vblank_rise && int_en)
        irq_pend <= 1'b1;
      else if (iack_clr || (int_en_wr && !int_en_val))
        irq_pend <= 1'b0;
    end
  end

  assign ipl_n = irq_pend ? IPL_LVL4 : IPL_NONE;

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle responder: DTACK timing, read-data latch, program-ROM fetch
// handshake and the autovectored VBLANK interrupt.
module m68k_bus_ctrl
  import m68k_bus_pkg::*;
#(
  parameter int RAM_WAIT  = 1,
  parameter int IO_WAIT   = 0,
  parameter int OPEN_WAIT = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  m68k_bus_if.slave   bus,
  input  logic        prog_rom_cs,
  input  logic        ram_cs,
  input  logic        shared_ram_cs,
  input  logic        pal_cs,
  input  logic        vblank_cs,
  input  logic        int_en_cs,
  input  logic        reg_cs,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  shared_dout,
  input  logic [15:0] pal_dout,
  input  logic        vblank,
  output logic        rom_req,
  output logic [22:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data
);

  state_t             state, state_d;
  sel_t               sel, sel_q;
  logic               as_q, start, is_iack, rw_q, rom_abort;
  logic               wait_exit, rom_done, iack_clr, int_en_wr;
  logic [CNT_W-1:0]   wait_cnt, wait_load;
  logic [15:0]        read_mux;

  assign start   = as_q & ~bus.cpu_as_n;
  assign is_iack = (bus.cpu_fc == FC_IACK);
  assign sel     = decode_sel(ram_cs, shared_ram_cs, pal_cs, vblank_cs, int_en_cs, reg_cs);

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    wait_load = CNT_W'(OPEN_WAIT);
    unique case (sel)
      SEL_RAM, SEL_SHARED, SEL_PAL:   wait_load = CNT_W'(RAM_WAIT);
      SEL_VBLANK, SEL_INT_EN, SEL_REG: wait_load = CNT_W'(IO_WAIT);
      default:                         wait_load = CNT_W'(OPEN_WAIT);
    endcase
  end

  always_comb begin
    read_mux = OPEN_BUS;
    unique case (sel_q)
      SEL_RAM:    read_mux = ram_dout;
      SEL_PAL:    read_mux = pal_dout;
      SEL_SHARED: read_mux = {8'hFF, shared_dout};
      SEL_VBLANK: read_mux = {15'h0, vblank};
      default:    read_mux = OPEN_BUS;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    wait_exit = 1'b0;
    rom_done  = 1'b0;
    unique case (state)
      IDLE: if (start) state_d = is_iack ? IACK : (prog_rom_cs ? ROM : WAIT);
      ROM: if (rom_ack) begin
        rom_done = 1'b1;
        state_d  = (rom_abort || bus.cpu_as_n) ? IDLE : ACK;
      end
      WAIT: if (bus.cpu_as_n) state_d = IDLE;
        else if (wait_cnt == '0) begin
          wait_exit = 1'b1;
          state_d   = ACK;
        end
      ACK, IACK: if (bus.cpu_as_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rom_req         = (state == ROM);
    bus.cpu_dtack_n = (state != ACK);
    bus.cpu_vpa_n   = (state != IACK);
    iack_clr        = (state == IDLE) && start && is_iack;
    int_en_wr       = wait_exit && (sel_q == SEL_INT_EN) && !rw_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      as_q        <= 1'b1;
      sel_q       <= SEL_OPEN;
      rw_q        <= 1'b1;
      wait_cnt    <= '0;
      rom_abort   <= 1'b0;
      rom_addr    <= '0;
      bus.cpu_din <= 16'h0000;
    end else begin
      as_q <= bus.cpu_as_n;
      if (state == IDLE && start) begin
        sel_q     <= sel;
        rw_q      <= bus.cpu_rw;
        wait_cnt  <= wait_load;
        rom_abort <= 1'b0;
        rom_addr  <= bus.cpu_a[23:1];
      end
      if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      // An aborted fetch must still see its ack before the arbiter is released.
      if (state == ROM && bus.cpu_as_n) rom_abort <= 1'b1;
      if (rom_done && state_d == ACK)   bus.cpu_din <= rom_data;
      if (wait_exit && rw_q)            bus.cpu_din <= read_mux;
    end
  end

  irq_ctrl u_irq_ctrl (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .vblank     (vblank),
    .iack_clr   (iack_clr),
    .int_en_wr  (int_en_wr),
    .int_en_val (bus.cpu_dout[0]),
    .ipl_n      (bus.cpu_ipl_n)
  );

endmodule
